// File: rtl/chan_seq_mux.sv
// chan_seq_mux: N-channel output sequencer. Advances over enabled channels on a
// strobe (auto) or jumps to a host-selected channel (manual), blanking after switches.
module chan_seq_mux #(
  parameter int N_CH      = 5,
  parameter int DATA_W    = 1,
  parameter int BLANK_CYC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    change_flag,
  input  logic [N_CH-1:0]         en_mask,
  input  logic                    sel_load,
  input  logic [$clog2(N_CH)-1:0] sel_in,
  input  logic [N_CH*DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    ch_valid,
  output logic [$clog2(N_CH)-1:0] cur_ch,
  output logic                    wrap,
  output logic                    sel_err,
  output logic                    none_en
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int BLK_W = 8;
  localparam logic [BLK_W-1:0] BLANK_LD = BLK_W'(BLANK_CYC);

  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [BLK_W-1:0]  blank_q, blank_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_wrap;
  logic              cur_en;
  logic              sel_ok;
  logic              do_switch;
  logic [DATA_W-1:0] cur_data;

  function automatic logic [BLK_W-1:0] dec_sat(input logic [BLK_W-1:0] v);
    return (v == '0) ? '0 : v - BLK_W'(1);
  endfunction

  assign none_en = ~|en_mask;

  // Loops compare against each legal index so an out-of-range sel_in never indexes en_mask.
  always_comb begin
    cur_en   = 1'b0;
    sel_ok   = 1'b0;
    cur_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_ch_q == CH_W'(i)) begin
        cur_en   = en_mask[i];
        cur_data = data_in[i*DATA_W +: DATA_W];
      end
      if (sel_in == CH_W'(i)) sel_ok = en_mask[i];
    end
  end

  // Lowest enabled index overall, overridden by the lowest enabled index above cur_ch.
  always_comb begin
    nxt_ch   = '0;
    nxt_wrap = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i]) nxt_ch = CH_W'(i);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i] && (CH_W'(i) > cur_ch_q)) begin
        nxt_ch   = CH_W'(i);
        nxt_wrap = 1'b0;
      end
    end
  end

  always_comb begin
    cur_ch_d  = cur_ch_q;
    do_switch = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (!none_en) begin
      if (!cur_en) begin
        cur_ch_d  = nxt_ch;
        do_switch = 1'b1;
        wrap_d    = nxt_wrap;
      end else if (!mode && change_flag) begin
        cur_ch_d  = nxt_ch;
        do_switch = 1'b1;
        wrap_d    = nxt_wrap;
      end else if (mode && sel_load) begin
        if (sel_ok) begin
          cur_ch_d  = sel_in;
          do_switch = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    blank_d = do_switch ? BLANK_LD : dec_sat(blank_q);
    valid_d = (blank_q == '0) && !none_en;
    data_d  = valid_d ? cur_data : '0;
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch_q <= '0;
      blank_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      blank_q  <= blank_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign cur_ch   = cur_ch_q;
  assign data_out = data_q;
  assign ch_valid = valid_q;
  assign wrap     = wrap_q;
  assign sel_err  = err_q;

endmodule
